// File: rtl/dz_pkg.sv
// Shared DZ11 receive-path definitions: RBUF bit positions, silo depth,
// alarm threshold and the helper that packs a received character into a
// silo entry.
package dz_pkg;

    // Silo geometry and alarm threshold
    localparam int DEPTH_LOG2 = 6;
    localparam int ALARM      = 16;
    localparam int ENTRY_W    = 15;

    // RBUF bit positions
    localparam int RB_DVAL    = 15;
    localparam int RB_OVRN    = 14;
    localparam int RB_FRME    = 13;
    localparam int RB_PARE    = 12;
    localparam int RB_LINE_HI = 10;
    localparam int RB_LINE_LO = 8;
    localparam int RB_DATA_HI = 7;
    localparam int RB_DATA_LO = 0;

    // Build a 15-bit silo entry; bit 11 is always zero.
    function automatic logic [ENTRY_W-1:0] packEntry(
        input logic       ovrn,
        input logic       frme,
        input logic       pare,
        input logic [2:0] line,
        input logic [7:0] data
    );
        logic [ENTRY_W-1:0] e;
        e                         = {ENTRY_W{1'b0}};
        e[RB_OVRN]                = ovrn;
        e[RB_FRME]                = frme;
        e[RB_PARE]                = pare;
        e[RB_LINE_HI:RB_LINE_LO]  = line;
        e[RB_DATA_HI:RB_DATA_LO]  = data;
        return e;
    endfunction

endpackage

// File: rtl/dzrx_fifo.sv
// Synchronous register FIFO for the DZ11 receiver silo.
// Ports: clk, rst (async, active-high), clr (sync clear), push/wdata,
// pop, head (entry at read pointer), count (0..DEPTH), empty, full.
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty is ignored.
module dzrx_fifo
    import dz_pkg::*;
#(
    parameter int AW = DEPTH_LOG2,
    parameter int W  = ENTRY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [AW:0]  count,
    output logic         empty,
    output logic         full
);

    localparam logic [AW:0] FULL_C = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_r [0:(1<<AW)-1];
    logic [AW:0]   wptr_r;
    logic [AW:0]   rptr_r;
    logic          doPush_s;
    logic          doPop_s;

    // Pointers carry one extra bit so full and empty are distinguishable
    assign count    = wptr_r - rptr_r;
    assign empty    = (count == {(AW+1){1'b0}});
    assign full     = (count == FULL_C);
    assign doPop_s  = pop & ~empty;
    assign doPush_s = push & (~full | doPop_s);
    assign head     = mem_r[rptr_r[AW-1:0]];

    // Read/write pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= {(AW+1){1'b0}};
            rptr_r <= {(AW+1){1'b0}};
        end else if (clr) begin
            wptr_r <= {(AW+1){1'b0}};
            rptr_r <= {(AW+1){1'b0}};
        end else begin
            if (doPush_s) begin
                wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (doPop_s) begin
                rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents need no reset since empty masks them
    always_ff @(posedge clk) begin
        if (doPush_s) begin
            mem_r[wptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/dzrx_silo.sv
// DZ11 receiver silo: 64-entry FIFO between the receive scanner and the
// RBUF register / RX interrupt controller.
// Ports: clk, rst (async, active-high), clr (sync clear), csrMSE, csrSAE,
// rxWRITE/rxLINE/rxDATA/rxFRME/rxPARE (received character strobe),
// rbufREAD (RBUF read bus cycle level), rbufDATA (RBUF image of the head),
// csrRDONE, csrSA, csrRRDY (to interrupt controller), siloCOUNT.
module dzrx_silo
    import dz_pkg::*;
#(
    parameter int DEPTH_LOG2 = dz_pkg::DEPTH_LOG2,
    parameter int ALARM      = dz_pkg::ALARM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  csrMSE,
    input  logic                  csrSAE,
    input  logic                  rxWRITE,
    input  logic [2:0]            rxLINE,
    input  logic [7:0]            rxDATA,
    input  logic                  rxFRME,
    input  logic                  rxPARE,
    input  logic                  rbufREAD,
    output logic [15:0]           rbufDATA,
    output logic                  csrRDONE,
    output logic                  csrSA,
    output logic                  csrRRDY,
    output logic [DEPTH_LOG2:0]   siloCOUNT
);

    localparam logic [4:0] ALARM_C = 5'(ALARM);

    logic                 rbufReadPrev_r;
    logic                 popEdge_s;
    logic                 doPop_s;
    logic                 pushReq_s;
    logic                 pushOk_s;
    logic                 drop_s;
    logic [7:0]           ovr_r;
    logic [4:0]           alarm_r;
    logic [4:0]           alarmNext_s;
    logic                 csrSA_r;
    logic [ENTRY_W-1:0]   entry_s;
    logic [ENTRY_W-1:0]   head_s;
    logic                 empty_s;
    logic                 full_s;
    logic [DEPTH_LOG2:0]  count_s;
    logic [15:0]          rbufData_s;

    // One pop per read bus cycle, however long rbufREAD is held
    assign popEdge_s = rbufREAD & ~rbufReadPrev_r;
    assign doPop_s   = popEdge_s & ~empty_s;
    assign pushReq_s = rxWRITE & csrMSE;
    assign pushOk_s  = pushReq_s & (~full_s | doPop_s);
    assign drop_s    = pushReq_s & full_s & ~doPop_s;
    assign entry_s   = packEntry(ovr_r[rxLINE], rxFRME, rxPARE, rxLINE, rxDATA);

    dzrx_fifo #(
        .AW (DEPTH_LOG2),
        .W  (ENTRY_W)
    ) uFifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (pushOk_s),
        .wdata (entry_s),
        .pop   (popEdge_s),
        .head  (head_s),
        .count (count_s),
        .empty (empty_s),
        .full  (full_s)
    );

    // rbufREAD history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbufReadPrev_r <= 1'b0;
        end else if (clr) begin
            rbufReadPrev_r <= 1'b0;
        end else begin
            rbufReadPrev_r <= rbufREAD;
        end
    end

    // Per-line overrun pending: set on a dropped character, consumed by the
    // next stored character of the same line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_r <= 8'h00;
        end else if (clr) begin
            ovr_r <= 8'h00;
        end else if (drop_s) begin
            ovr_r[rxLINE] <= 1'b1;
        end else if (pushOk_s) begin
            ovr_r[rxLINE] <= 1'b0;
        end
    end

    // Alarm counter next value: saturating push count since the last read
    always_comb begin
        alarmNext_s = alarm_r;
        if (popEdge_s) begin
            alarmNext_s = pushOk_s ? 5'd1 : 5'd0;
        end else if (pushOk_s && (alarm_r != ALARM_C)) begin
            alarmNext_s = alarm_r + 5'd1;
        end else begin
            alarmNext_s = alarm_r;
        end
    end

    // Alarm counter and silo-alarm flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_r <= 5'd0;
            csrSA_r <= 1'b0;
        end else if (clr) begin
            alarm_r <= 5'd0;
            csrSA_r <= 1'b0;
        end else begin
            alarm_r <= alarmNext_s;
            csrSA_r <= (alarmNext_s == ALARM_C);
        end
    end

    // RBUF image: DVAL plus head entry, all zero when the silo is empty
    always_comb begin
        rbufData_s = 16'h0000;
        if (!empty_s) begin
            rbufData_s[RB_DVAL]          = 1'b1;
            rbufData_s[ENTRY_W-1:0]      = head_s;
        end else begin
            rbufData_s = 16'h0000;
        end
    end

    assign rbufDATA  = rbufData_s;
    assign csrRDONE  = ~empty_s;
    assign csrSA     = csrSA_r;
    assign csrRRDY   = csrSAE ? csrSA_r : ~empty_s;
    assign siloCOUNT = count_s;

endmodule

// File: doc/dzrx_silo.md
Name: dzrx_silo

Overview:
- DZ11 receiver silo: 64-entry FIFO between the eight-line receive UART scanner and the RBUF register / RX interrupt controller.
- Stores each received character with its line number and error flags.
- Generates csrRDONE, csrSA and csrRRDY; csrRRDY drives the RX interrupt-set input of the DZ11 interrupt controller.
- Pops one entry per RBUF read cycle; rbufREAD is the same signal the interrupt controller uses as RX interrupt done.

Parameters:
- DEPTH_LOG2, 6, log2 of silo depth (64 entries).
- ALARM, 16, number of characters stored since the last RBUF read that sets the silo alarm.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- clr  in  1  synchronous clear (CSR[CLR] or UBASR[INI])
- csrMSE  in  1  master scan enable; rxWRITE is ignored while 0
- csrSAE  in  1  silo alarm enable
- rxWRITE  in  1  one-cycle strobe: character received
- rxLINE  in  3  line number of the received character
- rxDATA  in  8  received character
- rxFRME  in  1  framing error
- rxPARE  in  1  parity error
- rbufREAD  in  1  RBUF read bus cycle; a level that may last several cycles
- rbufDATA  out  16  RBUF image of the silo head
- csrRDONE  out  1  silo not empty
- csrSA  out  1  silo alarm
- csrRRDY  out  1  RX ready; to the interrupt controller
- siloCOUNT  out  7  number of occupied entries, 0..64

Behaviour:
- Reset and clr (clr synchronous, same effect as reset):
  - FIFO empty; read/write pointers 0.
  - Alarm counter 0; overrun vector 0.
  - All outputs 0.
- Entry format (15 bits): OVRN[14], FRME[13], PARE[12], zeros[11], LINE[10:8], DATA[7:0].
- rbufDATA:
  - Bit 15 (DVAL) = csrRDONE; bits 14:0 = head entry when non-empty.
  - rbufDATA = 0 when empty.
- Push condition: rxWRITE & csrMSE & (not full, or pop in the same cycle).
  - A pushed character is visible on rbufDATA / csrRDONE the cycle after the push.
- Pop:
  - Occurs on the rising edge of rbufREAD (registered previous value); exactly one pop per read cycle however long rbufREAD is held.
  - Pop when empty is a no-op.
  - Head advances the cycle after the edge is detected.
- Overrun:
  - 8-bit pending vector, one bit per line.
  - rxWRITE & csrMSE while full with no simultaneous pop: character dropped; ovr[rxLINE] set.
  - The next stored character for that line carries OVRN=1, and ovr[rxLINE] clears in the same cycle.
  - Characters on other lines are unaffected.
- Simultaneous push and pop: both performed; siloCOUNT unchanged. At full with a pop, the push is accepted.
- Alarm counter (5 bits):
  - Increments on each accepted push; saturates at ALARM.
  - Pop edge resets it to 0, or to 1 if a push is accepted in the same cycle.
  - csrSA = (alarm counter == ALARM), registered.
- csrRRDY = csrSAE ? csrSA : csrRDONE. Combinational from registered terms, so a level with no glitches.
- csrMSE = 0: pushes ignored; stored contents, pops and flags continue normally.
- siloCOUNT wraps correctly across pointer wrap (pointers DEPTH_LOG2+1 bits wide; count = wptr − rptr).

Decomposition:
- Shared package dz_pkg holds:
  - RBUF bit positions (DVAL=15, OVRN=14, FRME=13, PARE=12, LINE=10:8, DATA=7:0).
  - Silo depth and alarm constants.
- One sub-module, dzrx_fifo: a synchronous register/distributed-RAM FIFO providing push, pop, head, count, empty and full.
- dzrx_silo itself holds:
  - rbufREAD edge detection.
  - Overrun vector.
  - Alarm counter.
  - CSR flag logic.

Test Plan:
- Push line 3, char 0x41, FRME=1 -> next cycle rbufDATA=0xA341, csrRDONE=1, csrRRDY=1 (SAE=0); 4-cycle rbufREAD -> a single pop, rbufDATA=0x0000, siloCOUNT=0.
- SAE=1, push 15 chars -> csrRRDY=0; 16th push -> csrSA=1, csrRRDY=1; one RBUF read -> csrSA=0 and siloCOUNT=15.
- Fill 64 entries, push line 5 char 0x55 -> dropped, siloCOUNT=64; pop once, push line 5 char 0x66 -> that entry reads 0xC566; following push on line 5 has OVRN=0.
- At full, push and pop edge in the same cycle -> push accepted, siloCOUNT stays 64, no overrun set.
- Write 100 chars with interleaved reads of the head -> data order preserved across pointer wrap; siloCOUNT matches the reference model every cycle.
- Mid-fill clr (and separately async rst) -> next cycle siloCOUNT=0, rbufDATA=0, csrSA=0, overrun vector 0; csrMSE=0 with rxWRITE -> no push.
